inst_alu_slice: RTL and testbench
=================================

Name: inst_alu_slice

Overview:
- Fetch/execute slice of the single-cycle MIPS datapath.
- A registered instruction ROM is indexed by a word address.
- Register-address and operand-B muxes (2:1, parameterised width) select the destination register and the ALU second operand.
- An opcode/funct-decoded ALU produces a 32-bit result plus branch/jump flags.
- The register file sits outside the block: it consumes rs/rt/wr addresses and returns rs_data/rt_data.

Parameters:
- ADDR_W, 5, ROM index width; depth = 2**ADDR_W words.
- MUX_W, 5/32, width of each mux2to1 instance (5 for the register-address mux, 32 for the operand mux).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- pc  in  32  word index into ROM
- rs_data  in  32  register-file read data for rs
- rt_data  in  32  register-file read data for rt
- instr  out  32  registered instruction
- rs_addr  out  5  instr[25:21]
- rt_addr  out  5  instr[20:16]
- wr_addr  out  5  destination register from the register-address mux
- imm_ext  out  32  extended instr[15:0]
- alu_b  out  32  operand-mux output
- alu_result  out  32  ALU result
- branch  out  1  branch-taken flag
- jump  out  1  jump flag

Behaviour:
- ROM, fixed contents (all other words 0x00000000):
  - word 0 = 0x00000000
  - word 1 = 0x20010005 (addi $1,$0,5)
  - word 2 = 0x2002000A (addi $2,$0,10)
  - word 3 = 0x00221820 (add)
  - word 4 = 0x00221822 (sub)
  - word 5 = 0x00221824 (and)
  - word 6 = 0x00221825 (or)
  - word 7 = 0x0022182A (slt)
  - word 8 = 0x10220002 (beq)
  - word 9 = 0x08000000 (j 0)
- ROM read timing:
  - instr <= ROM[pc[ADDR_W-1:0]] on each rising clk edge, so latency is 1 cycle.
  - If pc[31:ADDR_W] is non-zero, instr loads 0x00000000.
- Reset: while rst is low, instr is forced to 0 asynchronously and stays 0 until the first rising edge after rst goes high.
- Everything downstream of instr is combinational.
- Control decode:
  - reg_dst = 1 when opcode == 0.
  - alu_src = 1 for opcodes addi 001000, slti 001010, andi 001100, ori 001101, lw 100011, sw 101011.
- Register-address mux: wr_addr = reg_dst ? instr[15:11] : instr[20:16].
- Operand mux: alu_b = alu_src ? imm_ext : rt_data.
- Immediate extension: imm_ext is zero-extended for andi/ori and sign-extended from bit 15 otherwise.
- ALU ops, A = rs_data, B = alu_b, all arithmetic 32-bit modulo 2^32, no overflow trap:
  - opcode 0, funct 100000 add: A+B
  - funct 100010 sub: A-B
  - funct 100100: A&B
  - funct 100101: A|B
  - funct 101010 slt (signed): result 1 or 0
  - funct 000000 sll: B << instr[10:6]
  - any other funct: 0
  - addi/lw/sw: A+B
  - slti: signed compare, 1 or 0
  - andi: A&B
  - ori: A|B
  - beq 000100: result A-B, branch = (A==B)
  - bne 000101: result A-B, branch = (A!=B)
  - j 000010: jump=1, result 0
  - unknown opcode: result 0
- Flags: branch and jump are 0 except in the cases listed above.
- Reset output state (instr = 0, decoded as sll by 0):
  - wr_addr = 0, rs_addr = rt_addr = 0
  - imm_ext = 0, alu_b = rt_data
  - alu_result = rt_data
  - branch = 0, jump = 0
- Reset mid-operation: asserting rst clears instr immediately without waiting for a clock edge, and outputs revert to the reset state.

Test Plan:
- Reset then pc=0..4 on successive edges:
  - instr follows one cycle later: 0x00000000, 0x20010005, 0x2002000A, 0x00221820, 0x00221822.
  - instr[5:0] after the pc=4 edge = 100010.
- pc=1, rs_data=0:
  - wr_addr=1, imm_ext=5, alu_b=5, alu_result=5.
- pc=3, rs_data=5, rt_data=10:
  - wr_addr=3, alu_result=15.
  - Then pc=4: alu_result=0xFFFFFFFB.
  - Then pc=7: alu_result=1.
- pc=8:
  - rs=rt=7: branch=1, alu_result=0.
  - rs=7, rt=8: branch=0.
  - Then pc=9: jump=1.
- pc=0x00000040 (out of range): instr=0x00000000, alu_result=rt_data.
- Assert rst low mid-clock while instr=0x00221820:
  - instr drops to 0 before the next edge, branch=0, jump=0.
  - Normal operation resumes on the first edge after release.

Source files
------------

// File: rtl/inst_alu_slice.sv
// rtl/inst_alu_slice.sv - fetch/execute slice: registered instruction ROM, operand muxes, decoded ALU

module mux2to1 #(
  parameter int MUX_W = 32
) (
  input  logic             sel,
  input  logic [MUX_W-1:0] in0,
  input  logic [MUX_W-1:0] in1,
  output logic [MUX_W-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

module inst_alu_slice #(
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] instr,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  wr_addr,
  output logic [31:0] imm_ext,
  output logic [31:0] alu_b,
  output logic [31:0] alu_result,
  output logic        branch,
  output logic        jump
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] idx);
    case (32'(idx))
      32'd1:   rom_word = 32'h20010005;
      32'd2:   rom_word = 32'h2002000A;
      32'd3:   rom_word = 32'h00221820;
      32'd4:   rom_word = 32'h00221822;
      32'd5:   rom_word = 32'h00221824;
      32'd6:   rom_word = 32'h00221825;
      32'd7:   rom_word = 32'h0022182A;
      32'd8:   rom_word = 32'h10220002;
      32'd9:   rom_word = 32'h08000000;
      default: rom_word = 32'h00000000;
    endcase
  endfunction

  logic [31:0] instr_d;
  logic [31:0] instr_q;

  // Addresses beyond the ROM depth fetch a zero word rather than aliasing.
  always_comb begin
    instr_d = 32'h00000000;
    if (pc[31:ADDR_W] == '0) begin
      instr_d = rom_word(pc[ADDR_W-1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= 32'h00000000;
    end else begin
      instr_q <= instr_d;
    end
  end

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic        reg_dst;
  logic        alu_src;
  logic        zero_ext;

  assign instr   = instr_q;
  assign opcode  = instr_q[31:26];
  assign funct   = instr_q[5:0];
  assign shamt   = instr_q[10:6];
  assign rs_addr = instr_q[25:21];
  assign rt_addr = instr_q[20:16];

  always_comb begin
    reg_dst  = (opcode == OP_RTYPE);
    alu_src  = 1'b0;
    zero_ext = 1'b0;
    case (opcode)
      OP_ADDI, OP_SLTI, OP_LW, OP_SW: alu_src = 1'b1;
      OP_ANDI, OP_ORI: begin
        alu_src  = 1'b1;
        zero_ext = 1'b1;
      end
      default: ;
    endcase
  end

  assign imm_ext = zero_ext ? {16'h0000, instr_q[15:0]}
                            : {{16{instr_q[15]}}, instr_q[15:0]};

  mux2to1 #(.MUX_W(5)) u_wr_mux (
    .sel (reg_dst),
    .in0 (instr_q[20:16]),
    .in1 (instr_q[15:11]),
    .out (wr_addr)
  );

  mux2to1 #(.MUX_W(32)) u_b_mux (
    .sel (alu_src),
    .in0 (rt_data),
    .in1 (imm_ext),
    .out (alu_b)
  );

  logic [31:0] sum;
  logic [31:0] diff;
  logic        lt_signed;

  assign sum       = rs_data + alu_b;
  assign diff      = rs_data - alu_b;
  assign lt_signed = $signed(rs_data) < $signed(alu_b);

  always_comb begin
    alu_result = 32'h00000000;
    branch     = 1'b0;
    jump       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_result = sum;
          FN_SUB:  alu_result = diff;
          FN_AND:  alu_result = rs_data & alu_b;
          FN_OR:   alu_result = rs_data | alu_b;
          FN_SLT:  alu_result = {31'b0, lt_signed};
          FN_SLL:  alu_result = alu_b << shamt;
          default: alu_result = 32'h00000000;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_result = sum;
      OP_SLTI: alu_result = {31'b0, lt_signed};
      OP_ANDI: alu_result = rs_data & alu_b;
      OP_ORI:  alu_result = rs_data | alu_b;
      OP_BEQ: begin
        alu_result = diff;
        branch     = (rs_data == alu_b);
      end
      OP_BNE: begin
        alu_result = diff;
        branch     = (rs_data != alu_b);
      end
      OP_J:    jump = 1'b1;
      default: alu_result = 32'h00000000;
    endcase
  end

endmodule

// File: tb/tb_inst_alu_slice.sv
// tb/tb_inst_alu_slice.sv - directed scoreboard bench for inst_alu_slice

module tb_inst_alu_slice;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] instr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  wr_addr;
  logic [31:0] imm_ext;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        branch;
  logic        jump;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic [4:0]  wr;
    logic [31:0] imm;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
    logic        j;
  } exp_t;

  exp_t sb[$];

  inst_alu_slice #(.ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .instr      (instr),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .wr_addr    (wr_addr),
    .imm_ext    (imm_ext),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .branch     (branch),
    .jump       (jump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input exp_t e);
    chk({e.tag, ".instr"},  instr,               e.instr);
    chk({e.tag, ".rs"},     32'(rs_addr),        32'(e.rs_a));
    chk({e.tag, ".rt"},     32'(rt_addr),        32'(e.rt_a));
    chk({e.tag, ".wr"},     32'(wr_addr),        32'(e.wr));
    chk({e.tag, ".imm"},    imm_ext,             e.imm);
    chk({e.tag, ".alu_b"},  alu_b,               e.b);
    chk({e.tag, ".result"}, alu_result,          e.res);
    chk({e.tag, ".branch"}, 32'(branch),         32'(e.br));
    chk({e.tag, ".jump"},   32'(jump),           32'(e.j));
  endtask

  task automatic step(input logic [31:0] p, input logic [31:0] rs, input logic [31:0] rt,
                      input exp_t e);
    exp_t got;
    pc      = p;
    rs_data = rs;
    rt_data = rt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s.scoreboard observed=empty expected=entry", e.tag);
    end else begin
      got = sb.pop_front();
      check_all(got);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [31:0] i, input logic [4:0] rsa,
                              input logic [4:0] rta, input logic [4:0] wr,
                              input logic [31:0] imm, input logic [31:0] b,
                              input logic [31:0] res, input logic br, input logic j);
    exp_t e;
    e.tag = tag; e.instr = i; e.rs_a = rsa; e.rt_a = rta; e.wr = wr;
    e.imm = imm; e.b = b; e.res = res; e.br = br; e.j = j;
    return e;
  endfunction

  initial begin
    rst = 1'b0; pc = 32'h0; rs_data = 32'h0; rt_data = 32'h00001234;
    #12;
    // Reset state decodes as sll by 0, so the result mirrors rt_data.
    check_all(mk("reset", 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1234, 32'h1234, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b1;

    step(32'd0, 32'd0, 32'd0, mk("pc0", 32'h00000000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0));
    step(32'd1, 32'd0, 32'd0, mk("pc1", 32'h20010005, 0, 1, 1, 32'h5, 32'h5, 32'h5, 0, 0));
    step(32'd2, 32'd0, 32'd0, mk("pc2", 32'h2002000A, 0, 2, 2, 32'hA, 32'hA, 32'hA, 0, 0));
    step(32'd3, 32'd0, 32'd0, mk("pc3", 32'h00221820, 1, 2, 3, 32'h1820, 32'h0, 32'h0, 0, 0));
    step(32'd4, 32'd0, 32'd0, mk("pc4", 32'h00221822, 1, 2, 3, 32'h1822, 32'h0, 32'h0, 0, 0));
    chk("pc4.funct", 32'(instr[5:0]), 32'(6'b100010));

    step(32'd3, 32'd5, 32'd10, mk("add", 32'h00221820, 1, 2, 3, 32'h1820, 32'd10, 32'd15, 0, 0));
    step(32'd4, 32'd5, 32'd10, mk("sub", 32'h00221822, 1, 2, 3, 32'h1822, 32'd10, 32'hFFFFFFFB, 0, 0));
    step(32'd5, 32'd5, 32'd10, mk("and", 32'h00221824, 1, 2, 3, 32'h1824, 32'd10, 32'd0, 0, 0));
    step(32'd6, 32'd5, 32'd10, mk("or",  32'h00221825, 1, 2, 3, 32'h1825, 32'd10, 32'd15, 0, 0));
    step(32'd7, 32'd5, 32'd10, mk("slt", 32'h0022182A, 1, 2, 3, 32'h182A, 32'd10, 32'd1, 0, 0));
    step(32'd7, 32'hFFFFFFFF, 32'd1,
         mk("slt_neg", 32'h0022182A, 1, 2, 3, 32'h182A, 32'd1, 32'd1, 0, 0));
    step(32'd7, 32'd1, 32'hFFFFFFFF,
         mk("slt_pos", 32'h0022182A, 1, 2, 3, 32'h182A, 32'hFFFFFFFF, 32'd0, 0, 0));

    step(32'd8, 32'd7, 32'd7, mk("beq_eq", 32'h10220002, 1, 2, 2, 32'h2, 32'd7, 32'd0, 1, 0));
    step(32'd8, 32'd7, 32'd8, mk("beq_ne", 32'h10220002, 1, 2, 2, 32'h2, 32'd8, 32'hFFFFFFFF, 0, 0));
    step(32'd9, 32'd7, 32'd8, mk("j", 32'h08000000, 0, 0, 0, 32'h0, 32'd8, 32'd0, 0, 1));

    step(32'h40, 32'd3, 32'h55, mk("oob", 32'h0, 0, 0, 0, 32'h0, 32'h55, 32'h55, 0, 0));
    step(32'd10, 32'd3, 32'h66, mk("zero_word", 32'h0, 0, 0, 0, 32'h0, 32'h66, 32'h66, 0, 0));

    step(32'd3, 32'd5, 32'd10, mk("pre_rst", 32'h00221820, 1, 2, 3, 32'h1820, 32'd10, 32'd15, 0, 0));
    // Asynchronous reset mid-cycle: instr must clear well before the next edge.
    #2;
    rst = 1'b0;
    #1;
    check_all(mk("mid_rst", 32'h0, 0, 0, 0, 32'h0, 32'd10, 32'd10, 0, 0));
    @(posedge clk);
    #1;
    chk("rst_hold.instr", instr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(32'd9, 32'd0, 32'd4, mk("resume", 32'h08000000, 0, 0, 0, 32'h0, 32'd4, 32'd0, 0, 1));

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
